// File: rtl/demux_1_a_4_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_a_4_reg
// Description : Registered 1-to-4 stream distributor with a valid/ready
//               handshake and one registered entry per output channel.
//               Optional macro ROUND_ROBIN_EN adds i_auto, which routes
//               accepted words through a rotating channel pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_a_4_reg #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_Datos,
   input  logic [1:0]   i_sel,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [N-1:0] o_Datos_0,
   output logic [N-1:0] o_Datos_1,
   output logic [N-1:0] o_Datos_2,
   output logic [N-1:0] o_Datos_3,
   output logic [3:0]   o_valid,
   input  logic [3:0]   i_ready,
`ifdef ROUND_ROBIN_EN
   input  logic         i_auto,
`endif
   output logic         o_busy
);

   logic [1:0]   w_tgt;
   logic [3:0]   w_free;
   logic         w_accept;
   logic [3:0]   w_valid;
   logic [N-1:0] w_dat [4];

   // A channel can take a word if it is empty or is being drained this cycle.
   assign w_free   = ~w_valid | i_ready;
   assign o_ready  = w_free[w_tgt];
   assign w_accept = i_valid & o_ready;

`ifdef ROUND_ROBIN_EN
   logic [1:0] r_rr;

   assign w_tgt = i_auto ? r_rr : i_sel;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_rr <= 2'd0;
      else if (w_accept && i_auto)
         r_rr <= r_rr + 2'd1;
   end
`else
   assign w_tgt = i_sel;
`endif

   generate
      for (genvar k = 0; k < 4; k++) begin : g_ch
         logic         w_load;
         logic         r_v;
         logic [N-1:0] r_d;

         assign w_load = w_accept && (w_tgt == 2'(k));

         // Loading wins over draining so a same-cycle refill keeps the channel full.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_v <= 1'b0;
               r_d <= '0;
            end else if (w_load) begin
               r_v <= 1'b1;
               r_d <= i_Datos;
            end else if (i_ready[k]) begin
               r_v <= 1'b0;
            end
         end

         assign w_valid[k] = r_v;
         assign w_dat[k]   = r_d;
      end
   endgenerate

   assign o_valid   = w_valid;
   assign o_busy    = |w_valid;
   assign o_Datos_0 = w_dat[0];
   assign o_Datos_1 = w_dat[1];
   assign o_Datos_2 = w_dat[2];
   assign o_Datos_3 = w_dat[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_a_4_reg.sv
`default_nettype none
// Self-checking bench for demux_1_a_4_reg: directed scenarios plus random
// traffic compared against a per-channel occupancy model.
module tb_demux_1_a_4_reg;
   localparam int N = 4;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic [N-1:0] i_Datos;
   logic [1:0]   i_sel;
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
   logic [3:0]   o_valid;
   logic [3:0]   i_ready;
   logic         o_busy;
`ifdef ROUND_ROBIN_EN
   logic         i_auto;
`endif

   demux_1_a_4_reg #(.N(N)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_Datos   (i_Datos),
      .i_sel     (i_sel),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_Datos_0 (o_Datos_0),
      .o_Datos_1 (o_Datos_1),
      .o_Datos_2 (o_Datos_2),
      .o_Datos_3 (o_Datos_3),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
`ifdef ROUND_ROBIN_EN
      .i_auto    (i_auto),
`endif
      .o_busy    (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int           total = 0;
   int           bad   = 0;
   logic         m_full [4];
   logic [N-1:0] m_dat  [4];
   int           m_ptr;
   logic         auto_q = 1'b0;
   logic         acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_full[k] = 1'b0;
         m_dat[k]  = '0;
      end
      m_ptr = 0;
   endtask

   task automatic check_outs(input string tag);
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = m_full[k];
      chk({tag, "_valid"}, 32'(o_valid), 32'(ev));
      chk({tag, "_busy"},  32'(o_busy),  32'(ev != 4'b0000));
      chk({tag, "_d0"},    32'(o_Datos_0), 32'(m_dat[0]));
      chk({tag, "_d1"},    32'(o_Datos_1), 32'(m_dat[1]));
      chk({tag, "_d2"},    32'(o_Datos_2), 32'(m_dat[2]));
      chk({tag, "_d3"},    32'(o_Datos_3), 32'(m_dat[3]));
   endtask

   // Called at posedge+1; drives one cycle, checks o_ready, then outputs after the edge.
   task automatic cycle(input logic [N-1:0] d, input logic [1:0] s, input logic v,
                        input logic [3:0] rdy, output logic a);
      int   tgt;
      logic er;
      i_Datos = d;
      i_sel   = s;
      i_valid = v;
      i_ready = rdy;
`ifdef ROUND_ROBIN_EN
      i_auto  = auto_q;
`endif
      #2;
      tgt = auto_q ? m_ptr : int'(s);
      er  = !m_full[tgt] || rdy[tgt];
      chk("o_ready", 32'(o_ready), 32'(er));
      a = v && er;
      @(posedge i_clk);
      for (int k = 0; k < 4; k++) begin
         if (a && tgt == k) begin
            m_full[k] = 1'b1;
            m_dat[k]  = d;
         end else if (rdy[k]) begin
            m_full[k] = 1'b0;
         end
      end
      if (a && auto_q) m_ptr = (m_ptr + 1) % 4;
      #1;
      check_outs("cyc");
   endtask

   task automatic mid_reset();
      i_valid = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      model_reset();
      check_outs("rst_mid");
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst   = 1'b1;
      i_Datos = '0;
      i_sel   = 2'd0;
      i_valid = 1'b0;
      i_ready = 4'b0000;
`ifdef ROUND_ROBIN_EN
      i_auto  = 1'b0;
`endif
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      check_outs("reset");
      i_rst = 1'b0;

      // Route a word to channel 2
      cycle(4'hA, 2'd2, 1'b1, 4'b1111, acc);
      chk("route_d2", 32'(o_Datos_2), 32'hA);
      chk("route_v",  32'(o_valid), 32'b0100);

      // Back-pressure on channel 1
      cycle(4'h7, 2'd1, 1'b1, 4'b0000, acc);
      for (int i = 0; i < 5; i++) begin
         cycle(4'h9, 2'd1, 1'b1, 4'b0000, acc);
         chk("bp_hold_d1", 32'(o_Datos_1), 32'h7);
      end
      cycle(4'h9, 2'd1, 1'b1, 4'b0010, acc);
      chk("bp_refill_d1", 32'(o_Datos_1), 32'h9);
      chk("bp_refill_v1", 32'(o_valid[1]), 32'h1);

      // Drain, then stream 1..8 into channel 3
      cycle(4'h0, 2'd0, 1'b0, 4'b1111, acc);
      for (int w = 1; w <= 8; w++) begin
         cycle(4'(w), 2'd3, 1'b1, 4'b1000, acc);
         chk("stream_d3", 32'(o_Datos_3), 32'(w));
         chk("stream_v3", 32'(o_valid[3]), 32'h1);
      end

      // Isolation: channel 0 stalled while others take traffic
      cycle(4'h5, 2'd0, 1'b1, 4'b0000, acc);
      for (int j = 1; j <= 3; j++) begin
         cycle(4'(j + 10), 2'(j), 1'b1, 4'b1110, acc);
         chk("iso_v0", 32'(o_valid[0]), 32'h1);
      end
      chk("iso_d1", 32'(o_Datos_1), 32'd11);
      chk("iso_d2", 32'(o_Datos_2), 32'd12);
      chk("iso_d3", 32'(o_Datos_3), 32'd13);

      // Random traffic, with a mid-run reset
      for (int i = 0; i < 300; i++) begin
         cycle(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), acc);
         if (i == 150) mid_reset();
      end

`ifdef ROUND_ROBIN_EN
      mid_reset();
      auto_q = 1'b1;
      for (int w = 5; w <= 9; w++)
         cycle(4'(w), 2'($urandom), 1'b1, 4'b1111, acc);
      chk("rr_d0", 32'(o_Datos_0), 32'd9);
      chk("rr_d1", 32'(o_Datos_1), 32'd6);
      chk("rr_d2", 32'(o_Datos_2), 32'd7);
      chk("rr_d3", 32'(o_Datos_3), 32'd8);
      auto_q = 1'b0;
      for (int i = 0; i < 100; i++) begin
         auto_q = 1'($urandom);
         cycle(4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), acc);
      end
      auto_q = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
